// File: rtl/freq_div_scheduler.sv
// ---------------------------------------------------------------------------
// freq_div_scheduler
//
// Arbitrates four requesters that each want to reprogram a shared clock
// divider. A granted divisor is checked for zero. A nonzero divisor runs the
// divider through a safe reload sequence before it is enabled again:
//   STOP (Enable low for SETTLE cycles) -> LOAD (ConfigDiv strobe)
//   -> PRIME (divider presets its phase counters) -> RUN (Ack pulse).
// A zero divisor is rejected with an Err pulse, and the divider keeps running
// as before. StopReq halts the divider and takes priority over every request.
//
// Parameters
//   SETTLE     cycles Enable is held low before a reload (1..15)
// Ports
//   Clk        system clock, rising edge
//   Reset      asynchronous, active-high reset
//   Req[3:0]   per-requester reconfiguration request (level, held until Ack)
//   DivBus     four 32-bit divisors, requester i on [32i+31:32i]
//   StopReq    level request to halt the divider
//   Ack[3:0]   one-cycle pulse: requester's divisor is now running
//   Err[3:0]   one-cycle pulse: requester's divisor rejected (zero)
//   Owner      index of the requester whose divisor is loaded
//   Busy       high while a reload is in progress (STOP, LOAD, PRIME)
//   DivOut     divisor presented to the divider
//   ConfigDiv  divider load strobe
//   Enable     divider run enable
// ---------------------------------------------------------------------------
module freq_div_scheduler #(
  parameter int unsigned SETTLE = 2
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [3:0]   Req,
  input  logic [127:0] DivBus,
  input  logic         StopReq,
  output logic [3:0]   Ack,
  output logic [3:0]   Err,
  output logic [1:0]   Owner,
  output logic         Busy,
  output logic [31:0]  DivOut,
  output logic         ConfigDiv,
  output logic         Enable
);

  typedef enum logic [2:0] {IDLE, STOP, LOAD, PRIME, RUN, HALT} state_t;

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  state_t      state;
  logic [1:0]  ptr;      // last granted requester
  logic [1:0]  win_q;    // latched winner
  logic [31:0] div_q;    // latched divisor of the winner
  logic        chk;      // a grant was latched last edge and awaits its zero check
  logic [3:0]  cnt;      // STOP cycles remaining

  // Round-robin pick, searching upward from the requester after ptr.
  logic        gnt_valid;
  logic [1:0]  gnt_idx;
  logic [31:0] gnt_div;

  always_comb begin
    logic [1:0] cand;
    gnt_valid = 1'b0;
    gnt_idx   = ptr;
    cand      = ptr;
    for (int i = 1; i <= 4; i++) begin
      cand = ptr + 2'(i);
      if (!gnt_valid && Req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
    gnt_div = DivBus[32*gnt_idx +: 32];
  end

  // NOTE: every register here, outputs included, is updated with
  // non-blocking assignments so all of them see pre-edge values of each other.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      ptr       <= 2'd3;
      win_q     <= '0;
      div_q     <= '0;
      chk       <= 1'b0;
      cnt       <= '0;
      Ack       <= '0;
      Err       <= '0;
      Owner     <= '0;
      Busy      <= 1'b0;
      DivOut    <= '0;
      ConfigDiv <= 1'b0;
      Enable    <= 1'b0;
    end else begin
      // Pulse outputs default low every cycle.
      Ack       <= '0;
      Err       <= '0;
      ConfigDiv <= 1'b0;

      case (state)
        IDLE, RUN: begin
          if (StopReq) begin
            state  <= HALT;
            chk    <= 1'b0;
            Enable <= 1'b0;
          end else if (chk) begin
            // The grant latched last edge is judged now; the requester sees
            // Ack or Err before this controller arbitrates again.
            chk <= 1'b0;
            if (div_q == '0) begin
              Err <= 4'b0001 << win_q;
            end else begin
              state  <= STOP;
              cnt    <= SETTLE_CNT;
              Enable <= 1'b0;
              Busy   <= 1'b1;
            end
          end else if (gnt_valid) begin
            win_q <= gnt_idx;
            div_q <= gnt_div;
            ptr   <= gnt_idx;
            chk   <= 1'b1;
          end
        end

        STOP: begin
          if (cnt <= 4'd1) begin
            state     <= LOAD;
            ConfigDiv <= 1'b1;
            DivOut    <= div_q;
            Owner     <= win_q;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        LOAD: state <= PRIME;

        PRIME: begin
          state  <= RUN;
          Enable <= 1'b1;
          Busy   <= 1'b0;
          Ack    <= 4'b0001 << win_q;
        end

        HALT: begin
          if (!StopReq) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_div_scheduler.sv
// ---------------------------------------------------------------------------
// tb_freq_div_scheduler
//
// Scenario tasks drive the scheduler and check level outputs inline. Each
// expected Ack/Err pulse is pushed to a scoreboard, together with the edge
// number where it must appear, when its request is driven. A negedge monitor
// pops and compares every pulse the DUT produces.
// ---------------------------------------------------------------------------
module tb_freq_div_scheduler;

  localparam int SETTLE = 2;
  localparam int LAT    = SETTLE + 3;   // grant edge -> Ack edge

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic [3:0]   Req = '0;
  logic [127:0] DivBus = '0;
  logic         StopReq = 1'b0;
  logic [3:0]   Ack, Err;
  logic [1:0]   Owner;
  logic         Busy, ConfigDiv, Enable;
  logic [31:0]  DivOut;

  freq_div_scheduler #(.SETTLE(SETTLE)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .DivBus(DivBus), .StopReq(StopReq),
    .Ack(Ack), .Err(Err), .Owner(Owner), .Busy(Busy), .DivOut(DivOut),
    .ConfigDiv(ConfigDiv), .Enable(Enable)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit          is_err;
    logic [1:0]  idx;
    int          at;
    logic [31:0] div;
  } ev_t;

  ev_t sb[$];
  int  total = 0;
  int  bad = 0;
  int  edge_n = 0;

  always @(posedge Clk) edge_n++;

  // Scoreboard monitor for Ack/Err pulses.
  ev_t        e;
  logic [3:0] exp_ack, exp_err;
  always @(negedge Clk) begin
    if (!Reset && (Ack != '0 || Err != '0)) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: ack=%b err=%b at edge %0d", Ack, Err, edge_n);
      end else begin
        e = sb.pop_front();
        exp_ack = e.is_err ? 4'b0000 : (4'b0001 << e.idx);
        exp_err = e.is_err ? (4'b0001 << e.idx) : 4'b0000;
        if ({Ack, Err} !== {exp_ack, exp_err} || edge_n != e.at) begin
          bad++;
          $display("FAIL pulse: got ack=%b err=%b edge=%0d, want ack=%b err=%b edge=%0d",
                   Ack, Err, edge_n, exp_ack, exp_err, e.at);
        end
        if (!e.is_err) begin
          total++;
          if ({Owner, DivOut, Enable, Busy} !== {e.idx, e.div, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL ack_state: got owner=%0d div=%0d en=%b busy=%b, want owner=%0d div=%0d en=1 busy=0",
                     Owner, DivOut, Enable, Busy, e.idx, e.div);
          end
        end
      end
    end
  end

  task automatic push_ev(input bit is_err, input int idx, input int at, input int div);
    ev_t n;
    n.is_err = is_err;
    n.idx    = 2'(idx);
    n.at     = at;
    n.div    = 32'(div);
    sb.push_back(n);
  endtask

  task automatic set_div(input int idx, input int val);
    DivBus[32*idx +: 32] = 32'(val);
  endtask

  // Drops each requester's Req bit once its Ack has been seen.
  task automatic wait_ack_drop(input string name, input int budget);
    int n = 0;
    while (Req != '0 && n < budget) begin
      @(negedge Clk);
      Req = Req & ~Ack;
      n++;
    end
    if (Req != '0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: req=%b still waiting after %0d cycles", name, Req, budget);
      Req = '0;
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge Clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_missing: %0d expected pulse(s) never seen", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic apply_reset();
    Reset = 1'b1;
    Req = '0;
    StopReq = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    #1;
    total++;
    if ({Ack, Err, Owner, Busy, DivOut, ConfigDiv, Enable} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got ack=%b err=%b owner=%0d busy=%b div=%0d cfg=%b en=%b, want all 0",
               Ack, Err, Owner, Busy, DivOut, ConfigDiv, Enable);
    end
    apply_reset();
    @(negedge Clk);
    total++;
    if ({Busy, ConfigDiv, Enable} !== 3'b000) begin
      bad++;
      $display("FAIL reset_idle: got busy=%b cfg=%b en=%b, want 000", Busy, ConfigDiv, Enable);
    end
  endtask

  // Requester 0, divisor 10, step through the full reload sequence.
  task automatic test_basic();
    int k;
    set_div(0, 10);
    Req = 4'b0001;
    k = edge_n + 1;
    push_ev(0, 0, k + LAT, 10);
    @(negedge Clk);   // after k: zero check pending
    total++;
    if ({Busy, Enable, ConfigDiv} !== 3'b000) begin
      bad++;
      $display("FAIL basic_grant: busy/en/cfg=%b, want 000", {Busy, Enable, ConfigDiv});
    end
    repeat (SETTLE) begin
      @(negedge Clk);  // STOP
      total++;
      if ({Busy, Enable, ConfigDiv} !== 3'b100) begin
        bad++;
        $display("FAIL basic_stop: busy/en/cfg=%b, want 100", {Busy, Enable, ConfigDiv});
      end
    end
    @(negedge Clk);   // LOAD
    total++;
    if ({Busy, Enable, ConfigDiv, DivOut, Owner} !== {3'b101, 32'd10, 2'd0}) begin
      bad++;
      $display("FAIL basic_load: busy/en/cfg=%b div=%0d owner=%0d, want 101 10 0",
               {Busy, Enable, ConfigDiv}, DivOut, Owner);
    end
    @(negedge Clk);   // PRIME
    total++;
    if ({Busy, Enable, ConfigDiv} !== 3'b100) begin
      bad++;
      $display("FAIL basic_prime: busy/en/cfg=%b, want 100", {Busy, Enable, ConfigDiv});
    end
    wait_ack_drop("basic", 20);
    @(negedge Clk);
    total++;
    if ({Ack, Enable, ConfigDiv} !== 6'b000010) begin
      bad++;
      $display("FAIL basic_run: ack=%b en=%b cfg=%b, want 0000 1 0", Ack, Enable, ConfigDiv);
    end
    drain("basic");
  endtask

  // Requester 2 with divisor 0 while requester 0 runs at 10.
  task automatic test_zero_div();
    int k;
    set_div(2, 0);
    Req = 4'b0100;
    k = edge_n + 1;
    push_ev(1, 2, k + 1, 0);
    repeat (2) @(negedge Clk);
    Req = '0;
    total++;
    if ({Enable, Busy, DivOut, Owner} !== {2'b10, 32'd10, 2'd0}) begin
      bad++;
      $display("FAIL zero_unchanged: en=%b busy=%b div=%0d owner=%0d, want 1 0 10 0",
               Enable, Busy, DivOut, Owner);
    end
    repeat (8) @(negedge Clk);
    total++;
    if ({Enable, Busy, DivOut} !== {2'b10, 32'd10}) begin
      bad++;
      $display("FAIL zero_still_run: en=%b busy=%b div=%0d, want 1 0 10", Enable, Busy, DivOut);
    end
    drain("zero_div");
  endtask

  // Divisor 1 is legal; pointer is past requester 2, so requester 1 wins.
  task automatic test_div_one();
    set_div(1, 1);
    Req = 4'b0010;
    push_ev(0, 1, edge_n + 1 + LAT, 1);
    wait_ack_drop("div_one", 30);
    drain("div_one");
  endtask

  // StopReq and Req[3] on the same edge while requester 1 runs.
  task automatic test_stop_priority();
    set_div(3, 6);
    StopReq = 1'b1;
    Req = 4'b1000;
    @(negedge Clk);
    total++;
    if ({Enable, Busy, ConfigDiv, Ack, Err} !== '0) begin
      bad++;
      $display("FAIL stop_halt: en=%b busy=%b cfg=%b ack=%b err=%b, want all 0",
               Enable, Busy, ConfigDiv, Ack, Err);
    end
    repeat (4) @(negedge Clk);
    total++;
    if ({Enable, Busy, DivOut} !== {2'b00, 32'd1}) begin
      bad++;
      $display("FAIL stop_hold: en=%b busy=%b div=%0d, want 0 0 1", Enable, Busy, DivOut);
    end
    StopReq = 1'b0;
    // HALT -> IDLE at the next edge, grant one edge later.
    push_ev(0, 3, edge_n + 2 + LAT, 6);
    wait_ack_drop("stop", 30);
    drain("stop");
  endtask

  // Requester 1 arrives during requester 0's STOP and is served afterwards.
  task automatic test_busy_ignore();
    int k;
    set_div(0, 7);
    set_div(1, 9);
    Req = 4'b0001;
    k = edge_n + 1;
    push_ev(0, 0, k + LAT, 7);
    repeat (2) @(negedge Clk);
    Req = 4'b0011;
    total++;
    if (Busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_flag: busy=%b, want 1", Busy);
    end
    push_ev(0, 1, k + LAT + 1 + LAT, 9);
    wait_ack_drop("busy_ignore", 40);
    drain("busy_ignore");
  endtask

  // Asynchronous reset during LOAD.
  task automatic test_reset_mid_load();
    set_div(2, 5);
    Req = 4'b0100;
    repeat (SETTLE + 2) @(negedge Clk);
    total++;
    if ({ConfigDiv, DivOut, Owner} !== {1'b1, 32'd5, 2'd2}) begin
      bad++;
      $display("FAIL load_before_reset: cfg=%b div=%0d owner=%0d, want 1 5 2", ConfigDiv, DivOut, Owner);
    end
    #2;
    Reset = 1'b1;
    Req = '0;
    #1;
    total++;
    if ({ConfigDiv, DivOut, Enable, Busy, Owner} !== '0) begin
      bad++;
      $display("FAIL async_reset: cfg=%b div=%0d en=%b busy=%b owner=%0d, want all 0",
               ConfigDiv, DivOut, Enable, Busy, Owner);
    end
    @(negedge Clk);
    Reset = 1'b0;
    repeat (12) @(negedge Clk);
    total++;
    if ({Enable, Busy, Ack} !== '0) begin
      bad++;
      $display("FAIL after_reset: en=%b busy=%b ack=%b, want 0 0 0000", Enable, Busy, Ack);
    end
  endtask

  // All four request continuously from reset; grant order must be 0,1,2,3.
  task automatic test_round_robin();
    int k0;
    apply_reset();
    for (int i = 0; i < 4; i++) set_div(i, 4);
    Req = 4'b1111;
    k0 = edge_n + 1;
    for (int i = 0; i < 4; i++) push_ev(0, i, k0 + LAT + i * (LAT + 1), 4);
    wait_ack_drop("round_robin", 200);
    drain("round_robin");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_div();
    test_div_one();
    test_stop_priority();
    test_busy_ignore();
    test_reset_mid_load();
    test_round_robin();
    repeat (3) @(negedge Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
